// File: rtl/inst_rom_responder.sv
// Word-addressed instruction memory serving a CPU fetch port with a
// req/gnt/rvalid handshake and a fixed number of wait states, plus a
// loader write port used to preload the program image.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   inst_req     fetch request, held until granted
//   inst_addr    fetch byte address, sampled at grant
//   inst_gnt     combinational accept (transfer on inst_req && inst_gnt)
//   inst_rvalid  one-cycle response strobe
//   inst_rdata   instruction word, zero unless inst_rvalid and no error
//   inst_err     with inst_rvalid: misaligned or out-of-range address
//   load_we      loader write strobe (has priority over fetch grants)
//   load_addr    loader word index
//   load_wdata   loader write data
module inst_rom_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [31:0]       inst_rdata,
    output logic              inst_err,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_wdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_q;
    logic [31:0]        mem [DEPTH];

    logic [31:0]        rd_addr;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_err;
    logic [31:0]        rd_word;
    logic               accept;

    // Program storage; never reset so a preloaded image survives reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_wdata;
        end
    end

    // Loader owns the cycle in IDLE; no grants at all while in reset.
    assign inst_gnt = rst && (state == S_IDLE) && !load_we;
    assign accept   = inst_req && inst_gnt;

    // Response source: live address when skipping WAIT, latched otherwise.
    // A loader write landing on the same edge that enters RESP is forwarded
    // so it is visible in the response; one during RESP is not.
    always_comb begin
        rd_addr = (state == S_IDLE) ? inst_addr : addr_q;
        rd_idx  = rd_addr[ADDR_W+1:2];
        rd_err  = (rd_addr[1:0] != 2'b00) ||
                  (rd_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
        rd_word = (load_we && (load_addr == rd_idx)) ? load_wdata : mem[rd_idx];
    end

    // Handshake FSM; response outputs are registered on entry to RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            inst_rvalid <= 1'b0;
            inst_rdata  <= '0;
            inst_err    <= 1'b0;
        end else begin
            inst_rvalid <= 1'b0;
            inst_rdata  <= '0;
            inst_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= inst_addr;
                        if (WAIT_CYCLES == 0) begin
                            state       <= S_RESP;
                            inst_rvalid <= 1'b1;
                            inst_err    <= rd_err;
                            inst_rdata  <= rd_err ? 32'h0 : rd_word;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state       <= S_RESP;
                        inst_rvalid <= 1'b1;
                        inst_err    <= rd_err;
                        inst_rdata  <= rd_err ? 32'h0 : rd_word;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: three instances (WAIT_CYCLES = 1, 0, 3) share
// one stimulus stream; a transaction-level model predicts grants, response
// timing and contents from the handshake rules.
module tb_inst_rom_responder;

    localparam int NDUT = 3;
    localparam int WAITS [NDUT] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        load_we = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_wdata = '0;

    logic [NDUT-1:0] gnt;
    logic [NDUT-1:0] rvalid;
    logic [NDUT-1:0] err;
    logic [31:0]     rdata [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycle of the last grant per instance and its address.
    int          cyc = 0;
    int          gcyc  [NDUT];
    logic [31:0] gaddr [NDUT];
    logic        gexp  [NDUT];
    logic [31:0] mref  [256];

    always #5 clk = ~clk;

    inst_rom_responder #(.ADDR_W(8), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_gnt(gnt[0]), .inst_rvalid(rvalid[0]), .inst_rdata(rdata[0]),
        .inst_err(err[0]), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata));

    inst_rom_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_gnt(gnt[1]), .inst_rvalid(rvalid[1]), .inst_rdata(rdata[1]),
        .inst_err(err[1]), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata));

    inst_rom_responder #(.ADDR_W(8), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_gnt(gnt[2]), .inst_rvalid(rvalid[2]), .inst_rdata(rdata[2]),
        .inst_err(err[2]), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    // One bus cycle: drive at negedge, check grant, advance model at posedge,
    // then check the response outputs of the new cycle.
    task automatic cycle(input logic we, input logic [7:0] la, input logic [31:0] wd,
                         input logic rq, input logic [31:0] ad);
        logic        v;
        logic        e;
        logic [31:0] d;
        @(negedge clk);
        load_we = we; load_addr = la; load_wdata = wd;
        inst_req = rq; inst_addr = ad;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            gexp[i] = !we && (cyc >= gcyc[i] + WAITS[i] + 2);
            check($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(gexp[i]));
        end
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            if (rq && gexp[i]) begin
                gcyc[i]  = cyc;
                gaddr[i] = ad;
            end
        end
        if (we) mref[la] = wd;
        cyc++;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            v = (cyc == gcyc[i] + WAITS[i] + 1);
            e = v && addr_bad(gaddr[i]);
            d = (v && !e) ? mref[(gaddr[i] / 4) % 256] : 32'h0;
            check($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(v));
            check($sformatf("err%0d", i), 32'(err[i]), 32'(e));
            check($sformatf("rdata%0d", i), rdata[i], d);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] ad);
        cycle(1'b0, 8'h0, 32'h0, 1'b1, ad);
    endtask

    // Asynchronous reset assertion; outputs must drop without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        load_we = 1'b0; inst_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_gnt%0d", tag, i), 32'(gnt[i]), 32'h0);
            check($sformatf("%s_rvalid%0d", tag, i), 32'(rvalid[i]), 32'h0);
            check($sformatf("%s_err%0d", tag, i), 32'(err[i]), 32'h0);
            check($sformatf("%s_rdata%0d", tag, i), rdata[i], 32'h0);
            gcyc[i] = -1000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        inst_req = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < NDUT; i++) begin
            gcyc[i] = -1000; gaddr[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'h0);
            check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
            check($sformatf("rst_err%0d", i), 32'(err[i]), 32'h0);
            check($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Preload the whole image through the loader port.
        for (int k = 0; k < 256; k++) begin
            w = $urandom;
            if (k == 0) w = 32'h3C01_0001;
            if (k == 1) w = 32'h0001_0840;
            if (k == 5) w = 32'h1000_0004;
            cycle(1'b1, 8'(k), w, 1'b0, 32'h0);
        end
        idle(2);

        // Fetch word 0 then hold a request for word 4.
        fetch(32'h0);
        fetch(32'h4);
        check("tp_word0", rdata[0], 32'h3C01_0001);
        fetch(32'h4);
        fetch(32'h4);
        fetch(32'h4);
        check("tp_word1", rdata[0], 32'h0001_0840);
        idle(6);

        // Back-to-back requests for the zero-wait instance.
        fetch(32'h8); fetch(32'hC); fetch(32'hC); fetch(32'hC);
        idle(6);

        // Error responses: misaligned and out of range.
        fetch(32'h6);
        idle(6);
        fetch(32'h400);
        idle(6);
        fetch(32'hFFFF_FFFF);
        idle(6);

        // Loader collides with a request: grant deferred, new word returned.
        cycle(1'b1, 8'd3, 32'hA5A5_0003, 1'b1, 32'hC);
        fetch(32'hC);
        idle(6);

        // Loader write during the response cycle reads the old word.
        fetch(32'h14);
        idle(1);
        check("rbw_old", rdata[0], 32'h1000_0004);
        cycle(1'b1, 8'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        idle(6);
        fetch(32'h14);
        idle(1);
        check("rbw_new", rdata[0], 32'hDEAD_BEEF);
        idle(6);

        // Reset while the 3-wait instance is still waiting.
        fetch(32'h0);
        idle(1);
        do_reset("midrst");
        idle(6);
        fetch(32'h4);
        idle(6);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
                1:       a = 32'($urandom) | 32'h0000_0400;
                default: a = {22'h0, 8'($urandom), 2'b00};
            endcase
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rndrst");
            end else begin
                cycle(($urandom_range(0, 4) == 0), 8'($urandom), $urandom,
                      ($urandom_range(0, 3) != 0), a);
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_rom_responder.md
Name: inst_rom_responder

Overview:
- Word-addressed instruction memory that answers the CPU fetch port of soc_top with a req/gnt/rvalid handshake and a configurable number of wait states.
- A loader write port lets the bench or a host preload the program after reset. This replaces the ad-hoc rom[] array in bench code.
- Sits between the CPU fetch unit and the external program image.

Parameters:
- ADDR_W, 8, log2 of memory depth in 32-bit words (256 words).
- WAIT_CYCLES, 1, idle cycles between accept and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (deassert synchronously in bench).
- inst_req  in  1  fetch request, held by CPU until granted.
- inst_addr  in  32  fetch byte address, sampled at grant.
- inst_gnt  out  1  combinational accept; a transfer occurs when inst_req && inst_gnt.
- inst_rvalid  out  1  one-cycle pulse, response valid.
- inst_rdata  out  32  instruction word; valid only with inst_rvalid, else 0.
- inst_err  out  1  with inst_rvalid: misaligned or out-of-range address.
- load_we  in  1  loader write strobe.
- load_addr  in  ADDR_W  loader word index.
- load_wdata  in  32  loader data.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, wait counter=0, inst_rvalid=0, inst_rdata=0, inst_err=0, latched address cleared. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - inst_gnt = !load_we.
  - On inst_req && inst_gnt: latch address. Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - inst_gnt = 0.
  - Counter counts WAIT_CYCLES cycles, then go to RESP.
- RESP:
  - inst_rvalid=1 for exactly one cycle with rdata/err.
  - inst_gnt=0. Next state IDLE.
- Latency: grant edge to rvalid cycle = WAIT_CYCLES+1 cycles. Minimum request spacing = WAIT_CYCLES+2 cycles.
- Word index = latched addr[ADDR_W+1:2].
- Error checks:
  - addr[1:0]!=0 -> inst_err=1, rdata=0.
  - addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2] -> inst_err=1, rdata=0.
  - Both conditions together -> single err response.
- Memory read happens in the RESP cycle from the latched index. A loader write completed before the RESP cycle is visible.
- Loader:
  - Write on rising edge when load_we=1, in any state.
  - load_we=1 in IDLE suppresses inst_gnt; the loader has priority and the request stays pending.
  - Write and RESP read to the same index in the same cycle: rdata returns the old word (read-before-write).
- inst_req deasserted while in WAIT/RESP: no effect; the response is still delivered.
- inst_addr changes after grant: ignored.
- Reset mid-transaction: pending response dropped, no rvalid after reset release.
- Counter width 4 bits. WAIT_CYCLES=0 skips WAIT entirely.

Test Plan:
- Reset, load word 0=32'h3C01_0001, word 1=32'h0001_0840; req addr 0 then addr 4 with WAIT_CYCLES=1 -> rvalid 2 cycles after each grant, rdata 3C010001 then 00010840, err=0, grants 3 cycles apart.
- WAIT_CYCLES=0, back-to-back requests addr 8,12 -> rvalid 1 cycle after each grant, no rvalid without a grant, gnt low during RESP.
- Req addr 32'h0000_0006 -> err=1, rdata=0. Req addr 32'h0000_0400 (ADDR_W=8) -> err=1, rdata=0.
- load_we=1 in same cycle as inst_req in IDLE -> gnt=0 that cycle. Grant the next cycle returns the newly written word.
- Loader writes word 5 = 32'hDEAD_BEEF in the RESP cycle of a fetch to word 5 holding 32'h1000_0004 -> rdata 10000004. Next fetch of word 5 -> DEADBEEF.
- Assert rst=0 during WAIT (WAIT_CYCLES=3) -> all outputs 0 immediately, no rvalid after release. The next request completes normally.
